// File: rtl/jesd_rx_pkg.sv
// Shared definitions for the JESD204B receive-side code-group synchronisation.
package jesd_rx_pkg;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    CS_INIT  = 2'd0,
    CS_CHECK = 2'd1,
    CS_DATA  = 2'd2
  } cs_state_t;

  // A K28.5 in either running disparity.
  function automatic logic is_k28_5(input logic [9:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

  // Coarse code-group validity: every legal 10-bit code carries 4, 5 or 6 ones.
  function automatic logic sym_is_valid(input logic [9:0] sym);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 10; i++) ones = ones + 4'(sym[i]);
    return (ones >= 4'd4) && (ones <= 4'd6);
  endfunction

endpackage

// File: rtl/rx_comma_detect.sv
// Combinational comma search over all ten bit offsets of a two-word window.
module rx_comma_detect
  import jesd_rx_pkg::*;
(
  input  logic [19:0] win,
  output logic [9:0]  match,
  output logic [3:0]  first_ofs,
  output logic        hit
);

  // Per-offset K28.5 compare; offset k starts k bits after the oldest bit.
  always_comb begin
    match = '0;
    for (int k = 0; k < 10; k++) match[k] = is_k28_5(win[19-k -: 10]);
  end

  // Lowest matching offset wins so the lock is deterministic.
  always_comb begin
    first_ofs = '0;
    hit       = |match;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) first_ofs = 4'(k);
    end
  end

endmodule

// File: rtl/rx_cgs_align.sv
// Receive comma alignment and CGS state machine driving SYNC~ back to the transmitter.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  CS_INIT  | searching all offsets for K28.5, SYNC~ low
//  CS_CHECK | offset frozen, counting consecutive aligned K28.5, SYNC~ low
//  CS_DATA  | aligned, SYNC~ high, counting consecutive invalid symbols
module rx_cgs_align
  import jesd_rx_pkg::*;
#(
  parameter int K_REQUIRED = 4,
  parameter int ERR_LIMIT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_raw,
  input  logic       i_raw_vld,
  input  logic       i_resync,
  output logic [9:0] o_data,
  output logic       o_vld,
  output logic       o_sync_n,
  output logic [1:0] o_state,
  output logic [3:0] o_align_ofs,
  output logic       o_k
);

  localparam logic [3:0] K_REQ_W   = 4'(K_REQUIRED);
  localparam logic [2:0] ERR_LIM_W = 3'(ERR_LIMIT);

  cs_state_t  state;
  logic [9:0] prev;
  logic [3:0] k_cnt;
  logic [2:0] err_cnt;

  logic [19:0] win;
  logic [9:0]  match_vec;
  logic [3:0]  first_ofs;
  logic        hit;
  logic [3:0]  use_ofs;
  logic [9:0]  sym;
  logic        sym_k;
  logic        sym_valid;
  logic [3:0]  k_inc;
  logic [2:0]  err_inc;

  assign win     = {prev, i_raw};
  assign o_state = state;

  rx_comma_detect u_comma_detect (
    .win       (win),
    .match     (match_vec),
    .first_ofs (first_ofs),
    .hit       (hit)
  );

  // Symbol at the offset in force after this edge: a fresh lock in CS_INIT takes effect at once.
  always_comb begin
    use_ofs = (state == CS_INIT && hit && !i_resync) ? first_ofs : o_align_ofs;
    sym     = '0;
    for (int k = 0; k < 10; k++) begin
      if (use_ofs == 4'(k)) sym = win[19-k -: 10];
    end
    sym_k     = is_k28_5(sym);
    sym_valid = sym_is_valid(sym);
    k_inc     = (k_cnt == 4'hF) ? k_cnt : k_cnt + 4'd1;
    err_inc   = (err_cnt == 3'h7) ? err_cnt : err_cnt + 3'd1;
  end

  // CGS state machine with registered data path and SYNC~.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CS_INIT;
      prev        <= '0;
      k_cnt       <= '0;
      err_cnt     <= '0;
      o_data      <= '0;
      o_vld       <= 1'b0;
      o_sync_n    <= 1'b0;
      o_align_ofs <= '0;
      o_k         <= 1'b0;
    end else begin
      o_vld <= 1'b0;
      if (i_raw_vld) begin
        prev   <= i_raw;
        o_data <= sym;
        o_k    <= sym_k;
      end
      if (i_resync) begin
        state    <= CS_INIT;
        k_cnt    <= '0;
        err_cnt  <= '0;
        o_sync_n <= 1'b0;
      end else if (i_raw_vld) begin
        case (state)
          CS_INIT: begin
            if (hit) begin
              o_align_ofs <= first_ofs;
              k_cnt       <= 4'd1;
              o_vld       <= 1'b1;
              if (K_REQ_W <= 4'd1) begin
                state    <= CS_DATA;
                err_cnt  <= '0;
                o_sync_n <= 1'b1;
              end else begin
                state <= CS_CHECK;
              end
            end
          end
          CS_CHECK: begin
            if (sym_k) begin
              k_cnt <= k_inc;
              o_vld <= 1'b1;
              if (k_inc >= K_REQ_W) begin
                state    <= CS_DATA;
                err_cnt  <= '0;
                o_sync_n <= 1'b1;
              end
            end else begin
              state <= CS_INIT;
              k_cnt <= '0;
            end
          end
          CS_DATA: begin
            if (!sym_valid) begin
              err_cnt <= err_inc;
              if (err_inc >= ERR_LIM_W) begin
                state    <= CS_INIT;
                k_cnt    <= '0;
                err_cnt  <= '0;
                o_sync_n <= 1'b0;
              end else begin
                o_vld <= 1'b1;
              end
            end else begin
              err_cnt <= '0;
              o_vld   <= 1'b1;
            end
          end
          default: begin
            state    <= CS_INIT;
            o_sync_n <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_cgs_align.sv
// Scoreboard bench for rx_cgs_align against a bit-window reference model.
module tb_rx_cgs_align;

  localparam int KREQ = 4;
  localparam int ELIM = 3;
  localparam logic [9:0] KN = 10'h0FA;
  localparam logic [9:0] KP = 10'h305;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] i_raw = '0;
  logic       i_raw_vld = 1'b0;
  logic       i_resync = 1'b0;
  logic [9:0] o_data;
  logic       o_vld;
  logic       o_sync_n;
  logic [1:0] o_state;
  logic [3:0] o_align_ofs;
  logic       o_k;

  rx_cgs_align #(.K_REQUIRED(KREQ), .ERR_LIMIT(ELIM)) dut (
    .clk(clk), .rst(rst), .i_raw(i_raw), .i_raw_vld(i_raw_vld), .i_resync(i_resync),
    .o_data(o_data), .o_vld(o_vld), .o_sync_n(o_sync_n), .o_state(o_state),
    .o_align_ofs(o_align_ofs), .o_k(o_k)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [9:0] data;
    logic       k;
    int         st;
    logic       sync;
    int         ofs;
  } exp_t;

  exp_t exp_q[$];
  logic [9:0] sym_q[$];
  int n_pass = 0;
  int n_total = 0;

  // reference model: 0 = searching, 1 = counting commas, 2 = synchronised
  int m_st, m_kc, m_ec, m_ofs;
  logic [9:0] m_prev;

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  function automatic logic [9:0] cand(input logic [9:0] p, input logic [9:0] r, input int k);
    logic [19:0] w;
    w = {p, r};
    w = w >> (10 - k);
    return w[9:0];
  endfunction

  function automatic logic is_comma(input logic [9:0] s);
    return (s == KN) || (s == KP);
  endfunction

  task automatic model_reset();
    m_st = 0; m_kc = 0; m_ec = 0; m_ofs = 0; m_prev = '0;
  endtask

  task automatic drive(input logic [9:0] raw, input logic vld, input logic rs);
    exp_t e;
    int ns, nk, ne, no, ones;
    logic [9:0] c;
    @(negedge clk);
    i_raw = raw; i_raw_vld = vld; i_resync = rs;
    ns = m_st; nk = m_kc; ne = m_ec; no = m_ofs;
    if (vld) begin
      if (m_st == 0) begin
        for (int k = 9; k >= 0; k--)
          if (is_comma(cand(m_prev, raw, k))) begin no = k; ns = 1; end
        if (ns == 1) begin
          nk = 1;
          if (KREQ <= 1) begin ns = 2; ne = 0; end
        end
      end else if (m_st == 1) begin
        if (is_comma(cand(m_prev, raw, m_ofs))) begin
          nk = (m_kc < 15) ? m_kc + 1 : 15;
          if (nk >= KREQ) begin ns = 2; ne = 0; end
        end else begin
          ns = 0; nk = 0;
        end
      end else begin
        c = cand(m_prev, raw, m_ofs);
        ones = $countones(c);
        if (ones < 4 || ones > 6) begin
          ne = (m_ec < 7) ? m_ec + 1 : 7;
          if (ne >= ELIM) begin ns = 0; nk = 0; ne = 0; end
        end else begin
          ne = 0;
        end
      end
    end
    if (rs) begin ns = 0; nk = 0; ne = 0; no = m_ofs; end
    e.vld  = vld && (ns != 0);
    e.data = cand(m_prev, raw, no);
    e.k    = is_comma(e.data);
    e.st   = ns;
    e.sync = (ns == 2);
    e.ofs  = no;
    if (vld) m_prev = raw;
    m_st = ns; m_kc = nk; m_ec = ne; m_ofs = no;
    exp_q.push_back(e);
  endtask

  // Serialise sym_q MSB-first behind sh junk bits and deliver it in 10-bit words.
  task automatic send_syms(input int sh, input bit alt_gap, input int gap_pct, input int rs_pct);
    bit bq[$];
    logic [9:0] w;
    for (int i = 0; i < sh; i++) bq.push_back(1'($urandom_range(0, 1)));
    foreach (sym_q[i]) for (int b = 9; b >= 0; b--) bq.push_back(sym_q[i][b]);
    while (bq.size() >= 10) begin
      for (int b = 9; b >= 0; b--) w[b] = bq.pop_front();
      if (alt_gap) drive(10'($urandom()), 1'b0, 1'b0);
      else while ($urandom_range(0, 99) < gap_pct) drive(10'($urandom()), 1'b0, 1'b0);
      drive(w, 1'b1, 1'($urandom_range(0, 99) < rs_pct));
    end
  endtask

  task automatic commas(input int n);
    for (int i = 0; i < n; i++) sym_q.push_back((i % 2 == 0) ? KN : KP);
  endtask

  task automatic settle_check(input string nm, input int st, input int sync);
    @(posedge clk); #2;
    chk({nm, " state"}, int'(o_state), st);
    chk({nm, " sync_n"}, int'(o_sync_n), sync);
  endtask

  // Monitor: every pushed expectation is compared just after the edge that consumes it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(o_state), e.st);
        chk("sync_n", int'(o_sync_n), int'(e.sync));
        chk("vld", int'(o_vld), int'(e.vld));
        if (e.vld) begin
          chk("data", int'(o_data), int'(e.data));
          chk("k", int'(o_k), int'(e.k));
          chk("align_ofs", int'(o_align_ofs), e.ofs);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    chk("rst data", int'(o_data), 0);
    chk("rst vld", int'(o_vld), 0);
    chk("rst sync_n", int'(o_sync_n), 0);
    chk("rst state", int'(o_state), 0);
    chk("rst ofs", int'(o_align_ofs), 0);
    chk("rst k", int'(o_k), 0);
    @(negedge clk); rst = 1'b0;

    // CGS stream shifted by 3 bits
    sym_q.delete(); commas(12);
    begin
      bit bq[$];
      logic [9:0] w;
      bq = '{1'b1, 1'b0, 1'b1};
      foreach (sym_q[i]) for (int b = 9; b >= 0; b--) bq.push_back(sym_q[i][b]);
      while (bq.size() >= 10) begin
        for (int b = 9; b >= 0; b--) w[b] = bq.pop_front();
        drive(w, 1'b1, 1'b0);
      end
    end
    @(posedge clk); #2;
    chk("shifted ofs", int'(o_align_ofs), 3);
    chk("shifted state", int'(o_state), 2);

    // aligned commas then data
    drive(10'h2AA, 1'b1, 1'b1);
    sym_q.delete(); sym_q.push_back(10'h2AA); commas(5);
    for (int i = 0; i < 4; i++) sym_q.push_back(10'h2AA);
    send_syms(0, 1'b0, 0, 0);
    @(posedge clk); #2;
    chk("aligned ofs", int'(o_align_ofs), 0);

    // broken CGS: 3 commas, a non-comma, then commas again
    drive(10'h2AA, 1'b1, 1'b1);
    sym_q.delete(); sym_q.push_back(10'h2AA); commas(3); sym_q.push_back(10'h155);
    commas(2);
    send_syms(0, 1'b0, 0, 0);
    settle_check("broken", 1, 0);

    // error limit in CS_DATA
    sym_q.delete(); commas(6);
    sym_q.push_back(10'h3FF); sym_q.push_back(10'h3FF); sym_q.push_back(10'h2AA);
    sym_q.push_back(10'h3FF); sym_q.push_back(10'h3FF);
    send_syms(0, 1'b0, 0, 0);
    settle_check("errs below limit", 2, 1);
    drive(10'h3FF, 1'b1, 1'b0);
    drive(10'h2AA, 1'b1, 1'b0);
    settle_check("err limit", 0, 0);

    // gapped CGS
    sym_q.delete(); sym_q.push_back(10'h2AA); commas(6); sym_q.push_back(10'h2AA);
    send_syms(0, 1'b1, 0, 0);
    settle_check("gapped", 2, 1);

    // resync on the edge that would complete CGS
    drive(10'h2AA, 1'b1, 1'b1);
    drive(10'h2AA, 1'b1, 1'b0);
    drive(KN, 1'b1, 1'b0);
    drive(KP, 1'b1, 1'b0);
    drive(KN, 1'b1, 1'b0);
    drive(KP, 1'b1, 1'b0);
    drive(KN, 1'b1, 1'b1);
    settle_check("resync", 0, 0);

    // randomised bursts of commas and data at random offsets
    for (int b = 0; b < 80; b++) begin
      int nc, nd;
      sym_q.delete();
      nc = $urandom_range(1, 6);
      nd = $urandom_range(0, 8);
      commas(nc);
      for (int i = 0; i < nd; i++) begin
        case ($urandom_range(0, 3))
          0: sym_q.push_back(10'h3FF);
          1: sym_q.push_back(10'($urandom()));
          default: sym_q.push_back(10'h2AA ^ 10'(1 << $urandom_range(0, 9)) ^ 10'(1 << $urandom_range(0, 9)));
        endcase
      end
      send_syms($urandom_range(0, 9), 1'b0, 20, 3);
    end

    // asynchronous reset while synchronised
    drive(10'h2AA, 1'b1, 1'b1);
    sym_q.delete(); sym_q.push_back(10'h2AA); commas(6); sym_q.push_back(10'h2AA);
    send_syms(0, 1'b0, 0, 0);
    settle_check("pre-reset", 2, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid rst data", int'(o_data), 0);
    chk("mid rst vld", int'(o_vld), 0);
    chk("mid rst sync_n", int'(o_sync_n), 0);
    chk("mid rst state", int'(o_state), 0);
    chk("mid rst ofs", int'(o_align_ofs), 0);
    chk("mid rst k", int'(o_k), 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    sym_q.delete(); commas(6);
    send_syms(7, 1'b0, 0, 0);
    settle_check("post-reset", 2, 1);

    @(negedge clk); i_raw_vld = 1'b0; i_resync = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
